// File: rtl/wb_icu186.sv
// wb_icu186: 80186-style interrupt control unit with a Wishbone register slave
module wb_icu186 #(
  parameter logic [7:0] VEC_BASE = 8'h0C,
  parameter logic [7:0] NMI_VEC  = 8'h02
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_adr_i,
  input  logic [1:0]  wb_sel_i,
  input  logic [15:0] wb_dat_i,
  output logic [15:0] wb_dat_o,
  output logic        wb_ack_o,
  input  logic [3:0]  int_req,
  input  logic        nmi_req,
  input  logic        inta,
  input  logic        nmia,
  output logic        intr,
  output logic        nmi,
  output logic [7:0]  vector
);
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;
  state_t state, state_nx;
  logic [3:0] s1, s2, s3, rise, mask, ltm, isr, req, elig, eoi_clr, ack_set;
  logic n1, n2, n3, nmi_rise, inta_d, acc, wr_lo, eoi, ack_int, unused;
  logic [3:0][2:0] pri;
  logic [2:0] primsk;
  logic [1:0] cur_id, win, top;
  logic [3:0] win_pri, top_pri;
  logic [15:0] rdata;
  assign unused = ^wb_dat_i[14:5];
  assign rise = s2 & ~s3;
  assign nmi_rise = n2 & ~n3;
  assign acc = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign wr_lo = acc & wb_we_i & wb_sel_i[0];
  assign eoi = acc & wb_we_i & (|wb_sel_i) & (wb_adr_i == 4'd1);
  assign ack_int = (state == S_REQ) & inta & ~inta_d;
  assign ack_set = ack_int ? 4'b1 << cur_id : 4'b0;
  assign eoi_clr = !eoi ? 4'b0 : wb_dat_i[15] ? 4'b1 << top : 4'b1 << wb_dat_i[1:0];
  assign vector = nmia ? NMI_VEC : VEC_BASE + {6'b0, cur_id};
  always_comb begin
    top = 2'd0;
    top_pri = 4'd8;
    for (int n = 0; n < 4; n++)
      if (isr[n] && {1'b0, pri[n]} < top_pri) begin
        top = 2'(n);
        top_pri = {1'b0, pri[n]};
      end
    elig = 4'b0;
    win = 2'd0;
    win_pri = 4'd8;
    for (int n = 0; n < 4; n++) begin
      elig[n] = req[n] & ~mask[n] & (pri[n] <= primsk) & ({1'b0, pri[n]} < top_pri);
      if (elig[n] && {1'b0, pri[n]} < win_pri) begin
        win = 2'(n);
        win_pri = {1'b0, pri[n]};
      end
    end
  end
  always_comb begin
    state_nx = (state == S_IDLE && |elig) ? S_REQ :
               (state == S_REQ && ack_int) ? S_WAIT :
               (state == S_WAIT && !inta) ? S_IDLE : state;
  end
  always_comb begin
    rdata = 16'h0;
    case (wb_adr_i)
      4'd4: rdata = {12'h0, mask};
      4'd5: rdata = {13'h0, primsk};
      4'd6: rdata = {12'h0, isr};
      4'd7: rdata = {12'h0, req};
      4'd8: rdata = {intr, nmi, 12'h0, cur_id};
      4'd12, 4'd13, 4'd14, 4'd15:
        rdata = {11'h0, ltm[wb_adr_i[1:0]], mask[wb_adr_i[1:0]], pri[wb_adr_i[1:0]]};
      default: rdata = 16'h0;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) state <= S_IDLE;
    else state <= state_nx;
  always_ff @(posedge clk)
    if (rst) begin
      {s1, s2, s3} <= '0;
      {n1, n2, n3} <= '0;
      {inta_d, intr, nmi, wb_ack_o} <= '0;
      wb_dat_o <= 16'h0;
      {isr, req, ltm} <= '0;
      mask <= 4'hF;
      pri <= {4{3'd7}};
      primsk <= 3'd7;
      cur_id <= 2'd0;
    end else begin
      {s3, s2, s1} <= {s2, s1, int_req};
      {n3, n2, n1} <= {n2, n1, nmi_req};
      inta_d <= inta;
      intr <= state_nx == S_REQ;
      nmi <= nmi_rise | (nmi & ~nmia);
      if (state == S_IDLE && |elig) cur_id <= win;
      for (int n = 0; n < 4; n++)
        req[n] <= ltm[n] ? s2[n] : rise[n] | (req[n] & ~ack_set[n]);
      isr <= (isr & ~eoi_clr) | ack_set;
      wb_ack_o <= acc;
      wb_dat_o <= acc ? rdata : 16'h0;
      if (wr_lo && wb_adr_i == 4'd4) mask <= wb_dat_i[3:0];
      if (wr_lo && wb_adr_i == 4'd5) primsk <= wb_dat_i[2:0];
      if (wr_lo && wb_adr_i[3:2] == 2'b11) begin
        pri[wb_adr_i[1:0]] <= wb_dat_i[2:0];
        mask[wb_adr_i[1:0]] <= wb_dat_i[3];
        ltm[wb_adr_i[1:0]] <= wb_dat_i[4];
      end
    end
endmodule
